// File: rtl/apb_slave_pkg.sv
// Shared types, default parameters and address-check helper for the APB register-memory completer.
package apb_slave_pkg;

  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_STATES = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // An access is illegal if it is not word-aligned or lands past the last implemented word.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input int unsigned lsb,
                                    input int unsigned depth);
    logic [31:0] mask;
    mask = (32'd1 << lsb) - 32'd1;
    return ((addr & mask) != 32'd0) || ((addr >> lsb) >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a requester (master) and this completer (slave).
interface apb_slave_mem_if
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_bank.sv
// Word-organised storage with byte-lane write enables, combinational read and synchronous clear.
module apb_mem_bank
  import apb_slave_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] word_d;

  assign rdata = mem_q[ridx];

  // Merge the enabled write lanes into the currently stored word.
  always_comb begin
    word_d = mem_q[widx];
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (wstrb[b]) word_d[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // Clear everything on reset, otherwise commit the merged word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[widx] <= word_d;
    end
  end
endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: setup/access FSM, wait-state countdown and registered response outputs.
//   state  | meaning
//   IDLE   | no transfer in flight, watching for a setup phase
//   ACCESS | transfer latched, counting wait states / presenting the response
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input logic             PCLK,
  input logic             PRESETn,
  apb_slave_mem_if.slave  bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  setup, do_setup, mem_we;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  rwrite, rerr;
  logic [DATA_WIDTH-1:0] rdata, resp_data;

  // A setup edge uses the live bus; otherwise the transfer latched at setup is used.
  assign setup     = bus.PSEL && !bus.PENABLE;
  assign raddr     = setup ? bus.PADDR  : addr_q;
  assign rwrite    = setup ? bus.PWRITE : write_q;
  assign rerr      = setup ? addr_err(32'(bus.PADDR), LSB, DEPTH) : err_q;
  assign resp_data = (rwrite || rerr) ? '0 : rdata;

  apb_mem_bank #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .widx  (addr_q[LSB +: IDX_W]),
    .wdata (bus.PWDATA),
    .wstrb (bus.PSTRB),
    .ridx  (raddr[LSB +: IDX_W]),
    .rdata (rdata)
  );

  // Next-state, wait countdown and response generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;
    do_setup  = 1'b0;

    case (state_q)
      IDLE: begin
        if (setup) do_setup = 1'b1;
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (!bus.PENABLE) begin
          do_setup = 1'b1;
        end else if (!pready_q) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = resp_data;
          end
        end else begin
          mem_we    = write_q && !err_q;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh setup (also mid-access) discards whatever was in flight.
    if (do_setup) begin
      state_d = ACCESS;
      addr_d  = bus.PADDR;
      write_d = bus.PWRITE;
      err_d   = rerr;
      if (WAIT_STATES == 0) begin
        cnt_d     = '0;
        pready_d  = 1'b1;
        pslverr_d = rerr;
        prdata_d  = resp_data;
      end else begin
        cnt_d     = 4'(WAIT_STATES);
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;
  assign bus.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench: dut0 has no wait states, dut1 has one; expected responses are queued by the driver.
module tb_apb_slave_mem;
  logic clk;
  logic rst_n;

  logic       psel    [2];
  logic       penable [2];
  logic       pwrite  [2];
  logic [9:0] paddr   [2];
  logic [31:0] pwdata [2];
  logic [3:0] pstrb   [2];
  logic       pready_w [2];

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;

  apb_slave_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus0 ();
  apb_slave_mem_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus1 ();

  assign bus0.PSEL    = psel[0];
  assign bus0.PENABLE = penable[0];
  assign bus0.PWRITE  = pwrite[0];
  assign bus0.PADDR   = paddr[0];
  assign bus0.PWDATA  = pwdata[0];
  assign bus0.PSTRB   = pstrb[0];
  assign bus1.PSEL    = psel[1];
  assign bus1.PENABLE = penable[1];
  assign bus1.PWRITE  = pwrite[1];
  assign bus1.PADDR   = paddr[1];
  assign bus1.PWDATA  = pwdata[1];
  assign bus1.PSTRB   = pstrb[1];
  assign pready_w[0]  = bus0.PREADY;
  assign pready_w[1]  = bus1.PREADY;

  apb_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_dut0 (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus0)
  );

  apb_slave_mem #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(1)) u_dut1 (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic mon_one(input int d, input logic rdy, input logic [31:0] rd, input logic er);
    exp_t e;
    if (rdy) begin
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected PREADY: actual=1 required=0", d);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk({e.name, " prdata"}, rd, e.data);
        chk({e.name, " pslverr"}, 32'(er), 32'(e.err));
      end
    end
  endtask

  // Monitor: compare the response whenever a completer presents PREADY.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon_one(0, bus0.PREADY, bus0.PRDATA, bus0.PSLVERR);
        mon_one(1, bus1.PREADY, bus1.PRDATA, bus1.PSLVERR);
      end
    end
  end

  // One full transfer on dut d; the dut index equals its wait-state count.
  task automatic xfer(input int d, input logic wr, input logic [9:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] ed, input logic ee, input string nm);
    exp_t e;
    int   cyc;
    e.data = ed;
    e.err  = ee;
    e.name = nm;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    cyc = 2;
    while (!pready_w[d] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk({nm, " latency"}, 32'(cyc), 32'(2 + d));
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end

    // 1: reset values, then a read of word 0
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst pready1",  32'(bus1.PREADY),  32'd0);
    chk("rst pslverr1", 32'(bus1.PSLVERR), 32'd0);
    chk("rst prdata1",  bus1.PRDATA,       32'd0);
    chk("rst pready0",  32'(bus0.PREADY),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 1'b0, 10'h000, 32'h0, 4'h0, 32'h0000_0000, 1'b0, "rd0 after rst");

    // 2: full-word write and readback with one wait state
    xfer(1, 1'b1, 10'h010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, "wr 010");
    xfer(1, 1'b0, 10'h010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "rd 010");

    // 3: byte strobes, including an all-zero strobe
    xfer(1, 1'b1, 10'h020, 32'hAAAA_AAAA, 4'hF, 32'h0, 1'b0, "wr 020 base");
    xfer(1, 1'b1, 10'h020, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, "wr 020 strb");
    xfer(1, 1'b0, 10'h020, 32'h0, 4'h0, 32'hAA22_AA44, 1'b0, "rd 020 strb");
    xfer(1, 1'b1, 10'h020, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, "wr 020 nostrb");
    xfer(1, 1'b0, 10'h020, 32'h0, 4'h0, 32'hAA22_AA44, 1'b0, "rd 020 nostrb");

    // 4: error responses and last legal word
    xfer(1, 1'b1, 10'h100, 32'h1234_5678, 4'hF, 32'h0, 1'b1, "wr 100 oob");
    xfer(1, 1'b0, 10'h003, 32'h0, 4'h0, 32'h0, 1'b1, "rd 003 misal");
    xfer(1, 1'b0, 10'h000, 32'h0, 4'h0, 32'h0, 1'b0, "rd 000 unchanged");
    xfer(1, 1'b1, 10'h0FC, 32'h5A5A_0FC0, 4'hF, 32'h0, 1'b0, "wr 0fc last");
    xfer(1, 1'b0, 10'h0FC, 32'h0, 4'h0, 32'h5A5A_0FC0, 1'b0, "rd 0fc last");

    // 5: back-to-back with no wait states
    xfer(0, 1'b1, 10'h004, 32'h0101_0101, 4'hF, 32'h0, 1'b0, "b2b wr 004");
    xfer(0, 1'b1, 10'h008, 32'h0202_0202, 4'hF, 32'h0, 1'b0, "b2b wr 008");
    xfer(0, 1'b1, 10'h00C, 32'h0303_0303, 4'hF, 32'h0, 1'b0, "b2b wr 00c");
    xfer(0, 1'b0, 10'h004, 32'h0, 4'h0, 32'h0101_0101, 1'b0, "b2b rd 004");
    xfer(0, 1'b0, 10'h008, 32'h0, 4'h0, 32'h0202_0202, 1'b0, "b2b rd 008");
    xfer(0, 1'b0, 10'h00C, 32'h0, 4'h0, 32'h0303_0303, 1'b0, "b2b rd 00c");

    // 6a: PSEL dropped in the access phase of a write
    xfer(1, 1'b1, 10'h030, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, "wr 030");
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 10'h030; pwdata[1] = 32'h0BAD_BAD0; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    psel[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort pready", 32'(bus1.PREADY), 32'd0);
    end
    @(posedge clk); #1;
    xfer(1, 1'b0, 10'h030, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, "rd 030 after abort");

    // 6b: reset pulsed during the wait cycle of a write
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 10'h034; pwdata[1] = 32'h7777_7777; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst pready",  32'(bus1.PREADY),  32'd0);
    chk("midrst pslverr", 32'(bus1.PSLVERR), 32'd0);
    chk("midrst prdata",  bus1.PRDATA,       32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, 10'h034, 32'h0, 4'h0, 32'h0, 1'b0, "rd 034 after rst");
    xfer(1, 1'b0, 10'h010, 32'h0, 4'h0, 32'h0, 1'b0, "rd 010 cleared");
    xfer(0, 1'b0, 10'h004, 32'h0, 4'h0, 32'h0, 1'b0, "rd 004 cleared");

    repeat (3) @(posedge clk);
    chk("q0 drained", 32'(q0.size()), 32'd0);
    chk("q1 drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB completer (slave) with a byte-addressable, word-organised register memory. It is the responder end of the APB interface driven by the team's APB master driver. It serves as the DUT for the APB verification environment and as a generic peripheral register bank. It supports programmable wait states, PSTRB byte-lane writes and PSLVERR on illegal accesses.

Parameters:
ADDR_WIDTH, 10, PADDR width in bits (byte address).
DATA_WIDTH, 32, PWDATA/PRDATA width; must be 32 or 64.
DEPTH, 64, number of implemented words; the word index is PADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
WAIT_STATES, 1, PREADY-low cycles inserted in every ACCESS phase; range 0..15.

Ports:
PCLK  input  1  clock, rising edge.
PRESETn  input  1  reset, synchronous, active-low.
PSEL  input  1  slave select.
PENABLE  input  1  access phase indicator.
PWRITE  input  1  1 = write, 0 = read.
PADDR  input  ADDR_WIDTH  byte address.
PWDATA  input  DATA_WIDTH  write data.
PSTRB  input  DATA_WIDTH/8  write byte-lane enables; ignored on reads.
PRDATA  output  DATA_WIDTH  read data; valid only when PREADY=1 and the transfer is a read.
PREADY  output  1  transfer completion, registered.
PSLVERR  output  1  error response, valid only when PREADY=1.

Behaviour:
- Clock and reset: one clock, PCLK. Synchronous active-low reset, PRESETn. All outputs are registered.
- Reset values (PRESETn=0 at a PCLK edge):
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - FSM enters IDLE and the wait counter is 0.
  - All memory words are cleared to 0.
- FSM states: IDLE, ACCESS.
  - IDLE: when PSEL=1 and PENABLE=0 (setup phase):
    - latch PADDR and PWRITE;
    - compute err = misaligned (low address bits != 0) OR word index >= DEPTH;
    - go to ACCESS.
  - Wait counter at the setup edge:
    - WAIT_STATES=0: set PREADY<=1.
    - Otherwise: load counter=WAIT_STATES and set PREADY<=0.
  - ACCESS with PSEL=1, PENABLE=1, PREADY=0: decrement the counter. When the counter reaches 1, set PREADY<=1 at that edge.
  - ACCESS with PSEL=1, PENABLE=1, PREADY=1 (completion edge):
    - on a write with no error, commit the PWDATA bytes where PSTRB[i]=1;
    - set PREADY<=0 and PSLVERR<=0;
    - return to IDLE.
- Read data: PRDATA and PSLVERR are loaded at the same edge that sets PREADY. PRDATA = mem[index] for a legal read, 0 on error or on a write.
- PSLVERR=err is driven only while PREADY=1. An erroring write modifies no memory.
- Latency: setup plus access is 2+WAIT_STATES cycles. Back-to-back transfers (completion cycle followed immediately by a new setup) must incur no idle bubble.
- Address stability: the address and direction used are those latched at setup. PWDATA and PSTRB are sampled at the completion edge.
- Protocol violations:
  - PSEL=0 in ACCESS: abort, no write, clear PREADY/PSLVERR, go to IDLE.
  - PSEL=1, PENABLE=0 in ACCESS: treat as a fresh setup (re-latch and restart the counter); the aborted transfer has no effect.
- Reset mid-transfer: the transfer is discarded, no write occurs, and all outputs are 0 at the next edge.
- PSTRB=0 on a write: the transfer completes normally with PSLVERR=0 and memory is unchanged.

Decomposition:
- Shared package apb_slave_pkg:
  - typedef enum of the FSM states {IDLE, ACCESS};
  - default parameter constants;
  - a function to compute the error flag from the address.
- One sub-module, apb_mem_bank: DEPTH x DATA_WIDTH array with byte-enable synchronous write, combinational read, and synchronous clear on PRESETn=0.
- The FSM, wait counter and output registers stay in apb_slave_mem.

Test Plan:
1. Reset with PRESETn=0 for 2 cycles, then read address 0x000 -> PREADY, PSLVERR, PRDATA all 0 during reset; read returns 0x00000000.
2. WAIT_STATES=1: write 0xDEADBEEF to 0x010 with PSTRB=4'hF, then read 0x010 -> each transfer takes 3 cycles; PREADY high only in the 3rd; read returns 0xDEADBEEF, PSLVERR=0.
3. Byte strobes: write 0x11223344 to 0x020 with PSTRB=4'b0101 over existing 0xAAAAAAAA -> read returns 0xAA22AA44.
4. Error cases:
   - write to 0x100 (index 64 >= DEPTH) -> PSLVERR=1 with PREADY.
   - read of 0x003 (misaligned) -> PSLVERR=1, PRDATA=0.
   - a following read of 0x000 shows memory unchanged.
5. Back-to-back writes to 0x004, 0x008, 0x00C with no IDLE gap, WAIT_STATES=0 -> each completes in 2 cycles; readback returns correct data.
6. Abort: PSEL dropped in the ACCESS wait cycle of a write to 0x030 -> PREADY never asserts and the memory word is unchanged. PRESETn pulsed mid-access of a write to 0x034 -> no write and outputs 0 next cycle.
